// File: rtl/fc_pkg.sv
// fc_pkg: shared FC neuron constants, FSM state enum and the saturating resize helper
package fc_pkg;
  localparam int BIT = 32;
  localparam int FRAC = 16;
  localparam int COL = 4;
  localparam int ROW = 4;
  localparam int CHANNEL = 2;
  localparam int BATCH = 10;
  localparam int N = ROW * COL * CHANNEL;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (BATCH > 1) ? $clog2(BATCH) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, DONE} state_e;
  function automatic logic signed [BIT-1:0] sat_bit(input logic signed [2*BIT-1:0] v);
    logic signed [2*BIT-1:0] hi;
    logic signed [2*BIT-1:0] lo;
    hi = {{(BIT+1){1'b0}}, {(BIT-1){1'b1}}};
    lo = {{(BIT+1){1'b1}}, {(BIT-1){1'b0}}};
    return (v > hi) ? {1'b0, {(BIT-1){1'b1}}} : (v < lo) ? {1'b1, {(BIT-1){1'b0}}} : v[BIT-1:0];
  endfunction
endpackage

// File: rtl/fc_mac_pipe.sv
// fc_mac_pipe: 2-stage multiply/accumulate (product reg, then accumulate + bias + saturate); ports feature/weight/bias/first/last/idx/valid in, result/result_idx/result_valid out
module fc_mac_pipe
  import fc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_,
  input  logic [BIT-1:0] feature_i,
  input  logic [BIT-1:0] weight_i,
  input  logic [BIT-1:0] bias_i,
  input  logic          first_i,
  input  logic          last_i,
  input  logic [BW-1:0] idx_i,
  input  logic          valid_i,
  output logic [BIT-1:0] result_o,
  output logic [BW-1:0] result_idx_o,
  output logic          result_valid_o
);
  logic signed [2*BIT-1:0] fx, wx, prod_d, prod_q, acc_q, sum, total;
  logic [BIT-1:0] bias_q, result_q;
  logic first_q, last_q, vld_q, result_valid_q;
  logic [BW-1:0] idx_q, result_idx_q;
  always_comb begin
    fx = {{BIT{feature_i[BIT-1]}}, feature_i};
    wx = {{BIT{weight_i[BIT-1]}}, weight_i};
    prod_d = (fx * wx) >>> FRAC;
    sum = (first_q ? '0 : acc_q) + prod_q;
    total = sum + {{BIT{bias_q[BIT-1]}}, bias_q};
  end
  always_ff @(posedge clk) begin
    if (rst_) begin
      prod_q <= '0;
      bias_q <= '0;
      first_q <= 1'b0;
      last_q <= 1'b0;
      idx_q <= '0;
      vld_q <= 1'b0;
      acc_q <= '0;
      result_q <= '0;
      result_idx_q <= '0;
      result_valid_q <= 1'b0;
    end else begin
      prod_q <= prod_d;
      bias_q <= (valid_i && last_i) ? bias_i : bias_q;
      first_q <= first_i;
      last_q <= last_i;
      idx_q <= idx_i;
      vld_q <= valid_i;
      acc_q <= vld_q ? sum : acc_q;
      result_q <= (vld_q && last_q) ? sat_bit(total) : result_q;
      result_idx_q <= (vld_q && last_q) ? idx_q : result_idx_q;
      result_valid_q <= vld_q && last_q;
    end
  end
  assign result_o = result_q;
  assign result_idx_o = result_idx_q;
  assign result_valid_o = result_valid_q;
endmodule

// File: rtl/fc_neuron_acc.sv
// fc_neuron_acc: FC neuron accumulator; start + data_in/data_valid load features, fb_weight/fb_bias request weight/bias words, result/result_idx/result_valid per neuron, busy/done status
module fc_neuron_acc
  import fc_pkg::*;
(
  input  logic           clk,
  input  logic           rst_,
  input  logic           start,
  input  logic [BIT-1:0] data_in,
  input  logic           data_valid,
  input  logic [BIT-1:0] weight,
  input  logic [BIT-1:0] bias,
  output logic           fb_weight,
  output logic           fb_bias,
  output logic [BIT-1:0] result,
  output logic [BW-1:0]  result_idx,
  output logic           result_valid,
  output logic           busy,
  output logic           done
);
  state_e state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [BW-1:0] b_q, b_d;
  logic [BIT-1:0] feat_q [N];
  logic [BIT-1:0] tag_feat_q;
  logic tag_first_q, tag_last_q, tag_vld_q;
  logic [BW-1:0] tag_idx_q;
  logic last_n, last_b;
  assign last_n = n_q == NW'(N - 1);
  assign last_b = b_q == BW'(BATCH - 1);
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    b_d = b_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        n_d = '0;
        b_d = '0;
      end
      LOAD: if (data_valid) begin
        n_d = last_n ? '0 : n_q + 1'b1;
        state_d = last_n ? MAC : LOAD;
      end
      MAC: begin
        n_d = last_n ? '0 : n_q + 1'b1;
        b_d = last_n ? (last_b ? '0 : b_q + 1'b1) : b_q;
        state_d = (last_n && last_b) ? DRAIN : MAC;
      end
      DRAIN: begin
        n_d = (n_q == NW'(2)) ? '0 : n_q + 1'b1;
        state_d = (n_q == NW'(2)) ? DONE : DRAIN;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q <= IDLE;
      n_q <= '0;
      b_q <= '0;
      tag_feat_q <= '0;
      tag_first_q <= 1'b0;
      tag_last_q <= 1'b0;
      tag_idx_q <= '0;
      tag_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      b_q <= b_d;
      tag_feat_q <= feat_q[n_q];
      tag_first_q <= n_q == '0;
      tag_last_q <= last_n;
      tag_idx_q <= b_q;
      tag_vld_q <= state_q == MAC;
    end
  end
  always_ff @(posedge clk) begin
    if (state_q == LOAD && data_valid) feat_q[n_q] <= data_in;
  end
  assign fb_weight = state_q == MAC;
  assign fb_bias = fb_weight;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  fc_mac_pipe u_pipe (
    .clk(clk),
    .rst_(rst_),
    .feature_i(tag_feat_q),
    .weight_i(weight),
    .bias_i(bias),
    .first_i(tag_first_q),
    .last_i(tag_last_q),
    .idx_i(tag_idx_q),
    .valid_i(tag_vld_q),
    .result_o(result),
    .result_idx_o(result_idx),
    .result_valid_o(result_valid)
  );
endmodule

// File: tb/tb_fc_neuron_acc.sv
// tb_fc_neuron_acc: directed frames with a weight/bias store model and a result scoreboard
module tb_fc_neuron_acc;
  import fc_pkg::*;
  logic clk = 1'b0;
  logic rst_ = 1'b1;
  logic start = 1'b0;
  logic data_valid = 1'b0;
  logic rearm = 1'b0;
  logic [BIT-1:0] data_in = '0;
  logic [BIT-1:0] weight = '0;
  logic [BIT-1:0] bias = '0;
  logic fb_weight, fb_bias, result_valid, busy, done;
  logic [BIT-1:0] result;
  logic [BW-1:0] result_idx;
  int tests = 0;
  int fails = 0;
  int ptr = 0;
  logic [BIT-1:0] fv [N];
  logic [BIT-1:0] wv [BATCH*N];
  logic [BIT-1:0] bv [BATCH];
  logic [BIT-1:0] exp_val [$];
  int exp_idx [$];

  fc_neuron_acc dut (
    .clk(clk), .rst_(rst_), .start(start), .data_in(data_in), .data_valid(data_valid),
    .weight(weight), .bias(bias), .fb_weight(fb_weight), .fb_bias(fb_bias),
    .result(result), .result_idx(result_idx), .result_valid(result_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rearm) ptr <= 0;
    else if (fb_weight) begin
      weight <= (ptr < BATCH*N) ? wv[ptr] : '0;
      bias <= (ptr < BATCH*N) ? bv[ptr/N] : '0;
      ptr <= ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic [BIT-1:0] model(input int b);
    longint acc = 0;
    for (int n = 0; n < N; n++)
      acc += (longint'($signed(fv[n])) * longint'($signed(wv[b*N+n]))) >>> FRAC;
    acc += longint'($signed(bv[b]));
    if (acc > 64'sd2147483647) return 32'h7FFFFFFF;
    if (acc < -64'sd2147483648) return 32'h80000000;
    return acc[31:0];
  endfunction

  task automatic run_frame(input bit gaps, input bit mid_start, input int abort_at);
    int reqs = 0, first_req = -1, last_req = -1, first_rv = -1, last_rv = -1;
    int strobes = 0, done_cyc = -1;
    bit mism = 0;
    for (int b = 0; b < BATCH; b++)
      if (abort_at == 0 || b*N + N + 2 < abort_at) begin
        exp_val.push_back(model(b));
        exp_idx.push_back(b);
      end
    @(negedge clk);
    data_valid = 1'b1;
    data_in = '1;
    @(negedge clk);
    data_valid = 1'b0;
    rearm = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rearm = 1'b0;
    chk("busy_in_load", busy, 1);
    for (int k = 0; k < N; k++) begin
      if (gaps && k % 5 == 2) begin
        data_valid = 1'b0;
        data_in = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
      end
      data_in = fv[k];
      data_valid = 1'b1;
      @(negedge clk);
    end
    data_valid = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (fb_weight !== fb_bias) mism = 1;
      if (fb_weight) begin
        if (first_req < 0) first_req = cyc;
        last_req = cyc;
        reqs++;
      end
      if (result_valid) begin
        strobes++;
        if (first_rv < 0) first_rv = cyc;
        last_rv = cyc;
        if (exp_val.size() == 0) chk("extra_result", 1, 0);
        else begin
          chk("result", result, exp_val.pop_front());
          chk("result_idx", result_idx, exp_idx.pop_front());
        end
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (abort_at > 0 && reqs == abort_at) begin
        rst_ = 1'b1;
        @(negedge clk);
        rst_ = 1'b0;
        chk("abort_outputs", {fb_weight, fb_bias, result_valid, busy, done, result_idx, result}, '0);
        chk("abort_pending", exp_val.size(), 0);
        exp_val.delete();
        exp_idx.delete();
        return;
      end
      start = mid_start && reqs == 50;
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", done_cyc >= 0, 1);
    chk("req_count", reqs, BATCH*N);
    chk("req_contiguous", last_req - first_req + 1, BATCH*N);
    chk("fb_bias_eq", mism, 0);
    chk("first_req_latency", first_req, 0);
    chk("strobes", strobes, BATCH);
    chk("first_rv_latency", first_rv - (first_req + N - 1), 3);
    chk("last_rv_latency", last_rv - last_req, 3);
    chk("done_latency", done_cyc - last_req, 4);
    chk("pending", exp_val.size(), 0);
    exp_val.delete();
    exp_idx.delete();
    @(negedge clk);
    chk("idle_after_done", {busy, done, fb_weight, result_valid}, 0);
  endtask

  task automatic set_identity();
    for (int n = 0; n < N; n++) fv[n] = 32'h00010000;
    for (int i = 0; i < BATCH*N; i++) wv[i] = 32'h00010000;
    for (int b = 0; b < BATCH; b++) bv[b] = b << FRAC;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", {fb_weight, fb_bias, result_valid, busy, done, result_idx, result}, '0);
    rst_ = 1'b0;
    set_identity();
    for (int b = 0; b < BATCH; b++) chk("identity_model", model(b), (N + b) << FRAC);
    run_frame(0, 1, 0);
    for (int n = 0; n < N; n++) fv[n] = (n == 0) ? 32'hFFFE0000 : 32'h00010000 * n;
    for (int i = 0; i < BATCH*N; i++) wv[i] = (i == 0) ? 32'h00018000 : 32'h0;
    for (int b = 0; b < BATCH; b++) bv[b] = 32'hFFFF8000;
    chk("signed_model", model(0), 32'hFFFC8000);
    run_frame(1, 0, 0);
    for (int n = 0; n < N; n++) fv[n] = 32'h7FFFFFFF;
    for (int i = 0; i < BATCH*N; i++) wv[i] = 32'h7FFFFFFF;
    for (int b = 0; b < BATCH; b++) bv[b] = 32'h0;
    chk("satpos_model", model(3), 32'h7FFFFFFF);
    run_frame(0, 0, 0);
    for (int i = 0; i < BATCH*N; i++) wv[i] = 32'h80000001;
    chk("satneg_model", model(3), 32'h80000000);
    run_frame(0, 0, 0);
    for (int n = 0; n < N; n++) fv[n] = int'($urandom_range(0, 524288)) - 262144;
    for (int i = 0; i < BATCH*N; i++) wv[i] = int'($urandom_range(0, 524288)) - 262144;
    for (int b = 0; b < BATCH; b++) bv[b] = int'($urandom_range(0, 1048576)) - 524288;
    run_frame(1, 0, 0);
    set_identity();
    run_frame(0, 0, 100);
    run_frame(0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
